// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes and
// the datapath mux-select values it drives.
package ctrl_pkg;

  typedef enum logic [3:0] {
    START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R,
    EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_MEMDATA   = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // Dispatch target out of DECODE; unsupported opcodes trap.
  function automatic state_e decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE: return MEMADR;
      OP_R:              return EXEC_R;
      OP_I:              return EXEC_I;
      OP_JAL:            return JAL;
      OP_JALR:           return JALR;
      OP_BRANCH:         return BRANCH;
      OP_LUI:            return LUI;
      OP_AUIPC:          return AUIPC;
      default:           return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes Moore datapath controls from the state register.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Funct7_5,
  input  logic       Branch_Taken,
  input  logic       Mem_Ready,
  output logic       Mem_Req,
  output logic       Mem_Write,
  output logic       Adr_Src,
  output logic       IR_Write,
  output logic       PC_Write,
  output logic       Reg_Write,
  output logic [1:0] Result_Src,
  output logic [1:0] ALU_SrcA,
  output logic [1:0] ALU_SrcB,
  output logic [1:0] ALU_Op,
  output logic [2:0] Imm_Ctrl,
  output logic       Illegal
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;

  // Funct fields are consumed by the downstream ALU decoder when ALU_Op selects it.
  logic unused_funct;
  assign unused_funct = ^{Funct3, Funct7_5};

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      START: begin
        if (hold_q == HOLD_LAST) state_d = FETCH;
        else                     hold_d  = hold_q + 4'd1;
      end
      FETCH:  if (Mem_Ready) state_d = DECODE;
      DECODE: state_d = decode_next(Opcode);
      MEMADR: state_d = (Opcode == OP_STORE) ? MEMWR : MEMRD;
      MEMRD:  if (Mem_Ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (Mem_Ready) state_d = FETCH;
      EXEC_R, EXEC_I, LUI, AUIPC, JAL: state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      JALR:   state_d = JAL;
      TRAP:   state_d = TRAP;
      default: state_d = START;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    Mem_Req    = 1'b0;
    Mem_Write  = 1'b0;
    Adr_Src    = 1'b0;
    IR_Write   = 1'b0;
    PC_Write   = 1'b0;
    Reg_Write  = 1'b0;
    Result_Src = RES_ALUOUT;
    ALU_SrcA   = SRCA_PC;
    ALU_SrcB   = SRCB_RS2;
    ALU_Op     = ALUOP_ADD;
    Imm_Ctrl   = IMM_I;
    Illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        Mem_Req    = 1'b1;
        IR_Write   = Mem_Ready;
        PC_Write   = Mem_Ready;
        Result_Src = RES_ALURESULT;
        ALU_SrcB   = SRCB_FOUR;
      end
      DECODE: begin
        // Branch/JAL targets are formed here from OldPC + immediate.
        ALU_SrcA = SRCA_OLDPC;
        ALU_SrcB = SRCB_IMM;
        if (Opcode == OP_BRANCH)   Imm_Ctrl = IMM_B;
        else if (Opcode == OP_JAL) Imm_Ctrl = IMM_J;
      end
      MEMADR: begin
        ALU_SrcA = SRCA_RS1;
        ALU_SrcB = SRCB_IMM;
        Imm_Ctrl = (Opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMRD: begin
        Mem_Req = 1'b1;
        Adr_Src = 1'b1;
      end
      MEMWB: begin
        Result_Src = RES_MEMDATA;
        Reg_Write  = 1'b1;
      end
      MEMWR: begin
        Mem_Req   = 1'b1;
        Mem_Write = 1'b1;
        Adr_Src   = 1'b1;
      end
      EXEC_R: begin
        ALU_SrcA = SRCA_RS1;
        ALU_Op   = ALUOP_FUNCT;
      end
      EXEC_I: begin
        ALU_SrcA = SRCA_RS1;
        ALU_SrcB = SRCB_IMM;
        ALU_Op   = ALUOP_FUNCT;
      end
      ALUWB: Reg_Write = 1'b1;
      BRANCH: begin
        ALU_SrcA = SRCA_RS1;
        ALU_Op   = ALUOP_SUB;
        PC_Write = Branch_Taken;
      end
      JAL: begin
        // PC takes the target held in ALUOut while the ALU forms OldPC+4 for the link.
        ALU_SrcA = SRCA_OLDPC;
        ALU_SrcB = SRCB_FOUR;
        PC_Write = 1'b1;
        Imm_Ctrl = IMM_J;
      end
      JALR: begin
        ALU_SrcA = SRCA_RS1;
        ALU_SrcB = SRCB_IMM;
      end
      LUI: begin
        ALU_SrcA = SRCA_ZERO;
        ALU_SrcB = SRCB_IMM;
        Imm_Ctrl = IMM_U;
      end
      AUIPC: begin
        ALU_SrcA = SRCA_OLDPC;
        ALU_SrcB = SRCB_IMM;
        Imm_Ctrl = IMM_U;
      end
      TRAP:    Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the
// FSM and checks the full output vector every cycle against hand-derived values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Funct7_5;
  logic       Branch_Taken;
  logic       Mem_Ready;
  logic       Mem_Req, Mem_Write, Adr_Src, IR_Write, PC_Write, Reg_Write, Illegal;
  logic [1:0] Result_Src, ALU_SrcA, ALU_SrcB, ALU_Op;
  logic [2:0] Imm_Ctrl;

  int compared   = 0;
  int mismatched = 0;

  multicycle_ctrl #(.RESET_PC_HOLD(1)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct3(Funct3), .Funct7_5(Funct7_5),
    .Branch_Taken(Branch_Taken), .Mem_Ready(Mem_Ready), .Mem_Req(Mem_Req),
    .Mem_Write(Mem_Write), .Adr_Src(Adr_Src), .IR_Write(IR_Write),
    .PC_Write(PC_Write), .Reg_Write(Reg_Write), .Result_Src(Result_Src),
    .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op),
    .Imm_Ctrl(Imm_Ctrl), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // {Mem_Req, Mem_Write, Adr_Src, IR_Write, PC_Write, Reg_Write,
  //  Result_Src, ALU_SrcA, ALU_SrcB, ALU_Op, Imm_Ctrl, Illegal}
  logic [17:0] obs;
  assign obs = {Mem_Req, Mem_Write, Adr_Src, IR_Write, PC_Write, Reg_Write,
                Result_Src, ALU_SrcA, ALU_SrcB, ALU_Op, Imm_Ctrl, Illegal};

  function automatic logic [17:0] o(
    input logic mreq, input logic mwr, input logic adr, input logic irw,
    input logic pcw, input logic rw, input logic [1:0] rs, input logic [1:0] sa,
    input logic [1:0] sb, input logic [1:0] op, input logic [2:0] imm,
    input logic ill);
    return {mreq, mwr, adr, irw, pcw, rw, rs, sa, sb, op, imm, ill};
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one full cycle to the next falling edge, let outputs settle, compare.
  task automatic step(input string tag, input logic [17:0] exp);
    @(negedge clk);
    #1;
    check(tag, exp);
  endtask

  localparam logic [17:0] ZERO   = 18'd0;
  localparam logic [17:0] ALUWB  = 18'b000001_00_00_00_00_000_0;

  initial begin
    rst = 1'b1; Opcode = 7'b0110011; Funct3 = 3'd0; Funct7_5 = 1'b0;
    Branch_Taken = 1'b0; Mem_Ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("start", ZERO);

    // R-type: FETCH, DECODE, EXEC_R, ALUWB
    step("r_fetch",  o(1,0,0,1,1,0, 2,0,2,0, 0,0));
    step("r_decode", o(0,0,0,0,0,0, 0,1,1,0, 0,0));
    step("r_exec",   o(0,0,0,0,0,0, 0,2,0,2, 0,0));
    step("r_wb",     ALUWB);

    // Load with three not-ready cycles in MEMRD
    Opcode = 7'b0000011;
    step("ld_fetch",  o(1,0,0,1,1,0, 2,0,2,0, 0,0));
    step("ld_decode", o(0,0,0,0,0,0, 0,1,1,0, 0,0));
    Mem_Ready = 1'b0;
    step("ld_memadr", o(0,0,0,0,0,0, 0,2,1,0, 0,0));
    step("ld_rd_w1",  o(1,0,1,0,0,0, 0,0,0,0, 0,0));
    step("ld_rd_w2",  o(1,0,1,0,0,0, 0,0,0,0, 0,0));
    step("ld_rd_w3",  o(1,0,1,0,0,0, 0,0,0,0, 0,0));
    Mem_Ready = 1'b1;
    #1;
    check("ld_rd_rdy", o(1,0,1,0,0,0, 0,0,0,0, 0,0));
    step("ld_wb",     o(0,0,0,0,0,1, 1,0,0,0, 0,0));

    // Store
    Opcode = 7'b0100011;
    step("st_fetch",  o(1,0,0,1,1,0, 2,0,2,0, 0,0));
    step("st_decode", o(0,0,0,0,0,0, 0,1,1,0, 0,0));
    step("st_memadr", o(0,0,0,0,0,0, 0,2,1,0, 1,0));
    step("st_memwr",  o(1,1,1,0,0,0, 0,0,0,0, 0,0));

    // Branch not taken, then taken
    Opcode = 7'b1100011;
    step("bn_fetch",  o(1,0,0,1,1,0, 2,0,2,0, 0,0));
    step("bn_decode", o(0,0,0,0,0,0, 0,1,1,0, 2,0));
    step("bn_branch", o(0,0,0,0,0,0, 0,2,0,1, 0,0));
    Branch_Taken = 1'b1;
    step("bt_fetch",  o(1,0,0,1,1,0, 2,0,2,0, 0,0));
    step("bt_decode", o(0,0,0,0,0,0, 0,1,1,0, 2,0));
    step("bt_branch", o(0,0,0,0,1,0, 0,2,0,1, 0,0));
    Branch_Taken = 1'b0;

    // JALR: FETCH, DECODE, JALR, JAL, ALUWB
    Opcode = 7'b1100111;
    step("jr_fetch",  o(1,0,0,1,1,0, 2,0,2,0, 0,0));
    step("jr_decode", o(0,0,0,0,0,0, 0,1,1,0, 0,0));
    step("jr_jalr",   o(0,0,0,0,0,0, 0,2,1,0, 0,0));
    step("jr_jal",    o(0,0,0,0,1,0, 0,1,2,0, 3,0));
    step("jr_wb",     ALUWB);

    // LUI uses the zero A-source and U immediate
    Opcode = 7'b0110111;
    step("lui_fetch",  o(1,0,0,1,1,0, 2,0,2,0, 0,0));
    step("lui_decode", o(0,0,0,0,0,0, 0,1,1,0, 0,0));
    step("lui_exec",   o(0,0,0,0,0,0, 0,3,1,0, 4,0));
    step("lui_wb",     ALUWB);

    // Store stalled in MEMWR, then reset mid-wait
    Opcode = 7'b0100011;
    step("sr_fetch",  o(1,0,0,1,1,0, 2,0,2,0, 0,0));
    step("sr_decode", o(0,0,0,0,0,0, 0,1,1,0, 0,0));
    Mem_Ready = 1'b0;
    step("sr_memadr", o(0,0,0,0,0,0, 0,2,1,0, 1,0));
    step("sr_memwr",  o(1,1,1,0,0,0, 0,0,0,0, 0,0));
    rst = 1'b1;
    step("sr_rst",    ZERO);
    rst = 1'b0;
    step("sr_fetch_nr", o(1,0,0,0,0,0, 2,0,2,0, 0,0));
    Mem_Ready = 1'b1;
    Opcode = 7'b1111111;
    #1;
    check("il_fetch",  o(1,0,0,1,1,0, 2,0,2,0, 0,0));
    step("il_decode", o(0,0,0,0,0,0, 0,1,1,0, 0,0));
    for (int i = 0; i < 10; i++) step($sformatf("trap_%0d", i), o(0,0,0,0,0,0, 0,0,0,0, 0,1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over several cycles. Drives datapath mux selects, register-file/memory/IR/PC enables, ALU operation class and the immediate-format select (Imm_Ctrl) for the immediate generator.
- Sits beside the datapath. Consumes opcode/funct fields from the instruction register, the branch-compare result and the memory ready handshake.

Parameters:
- RESET_PC_HOLD, 1, number of START cycles after reset with all outputs low (range 1-15).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- Opcode  in  7  IR[6:0]
- Funct3  in  3  IR[14:12]
- Funct7_5  in  1  IR[30]
- Branch_Taken  in  1  branch comparator result for current Funct3
- Mem_Ready  in  1  memory completes the current access this cycle
- Mem_Req  out  1  memory access request
- Mem_Write  out  1  request is a store
- Adr_Src  out  1  0 = PC, 1 = ALU result register
- IR_Write  out  1  latch fetched instruction and OldPC
- PC_Write  out  1  update PC
- Reg_Write  out  1  register-file write
- Result_Src  out  2  0 = ALUOut, 1 = MemData, 2 = ALU result
- ALU_SrcA  out  2  0 = PC, 1 = OldPC, 2 = RS1
- ALU_SrcB  out  2  0 = RS2, 1 = Immediate, 2 = constant 4
- ALU_Op  out  2  0 = add, 1 = subtract/compare, 2 = decode by funct
- Imm_Ctrl  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- Illegal  out  1  unsupported opcode trapped

Behaviour:
- Interface: one clock (clk); reset synchronous and active-high (rst). On rst the state goes to START; all outputs are 0 in START.
- Outputs are Moore, decoded from the state register, except IR_Write and PC_Write in FETCH, which are qualified by Mem_Ready.
- START: hold RESET_PC_HOLD cycles (internal counter), then go to FETCH.
- FETCH:
  - Mem_Req=1, Adr_Src=0, ALU_SrcA=0, ALU_SrcB=2, ALU_Op=0, Result_Src=2.
  - IR_Write=PC_Write=Mem_Ready.
  - Stay in FETCH while !Mem_Ready; go to DECODE when Mem_Ready.
- DECODE:
  - ALU_SrcA=1, ALU_SrcB=1, ALU_Op=0.
  - Imm_Ctrl=2 for branch, 3 for JAL, otherwise 0.
  - Next state by Opcode: load/store→MEMADR; R→EXEC_R; I-ALU→EXEC_I; JAL→JAL; JALR→JALR; branch→BRANCH; LUI→LUI; AUIPC→AUIPC; anything else→TRAP.
- MEMADR: ALU_SrcA=2, ALU_SrcB=1, Imm_Ctrl=1 for store else 0. Next: MEMRD (load) or MEMWR (store).
- MEMRD: Mem_Req=1, Adr_Src=1. Wait for Mem_Ready, then MEMWB.
- MEMWB: Result_Src=1, Reg_Write=1. Next: FETCH.
- MEMWR: Mem_Req=1, Mem_Write=1, Adr_Src=1. Wait for Mem_Ready, then FETCH.
- EXEC_R: ALU_SrcA=2, ALU_SrcB=0, ALU_Op=2. Next: ALUWB.
- EXEC_I: ALU_SrcA=2, ALU_SrcB=1, ALU_Op=2, Imm_Ctrl=0. Next: ALUWB.
- ALUWB: Result_Src=0, Reg_Write=1. Next: FETCH.
- BRANCH: ALU_SrcA=2, ALU_SrcB=0, ALU_Op=1, Result_Src=0, PC_Write=Branch_Taken. Next: FETCH.
- JAL: ALU_SrcA=1, ALU_SrcB=2, Result_Src=0, PC_Write=1, Imm_Ctrl=3. Writes PC from ALUOut (target computed in DECODE). Next: ALUWB (writes OldPC+4).
- JALR: ALU_SrcA=2, ALU_SrcB=1, Imm_Ctrl=0. Next: JAL.
- LUI: Imm_Ctrl=4, ALU_SrcB=1, ALU_Op=0, ALU_SrcA forced to zero-select 3. Next: ALUWB.
- AUIPC: ALU_SrcA=1, ALU_SrcB=1, Imm_Ctrl=4. Next: ALUWB.
- TRAP: Illegal=1, all enables 0. Exited only by rst.
- Imm_Ctrl defaults to 0 in states not listed above.
- Latency with Mem_Ready tied high:
  - R/I-ALU/AUIPC/LUI 4 cycles, load 5, store 4, branch 3, JAL 4, JALR 5.
- rst asserted in any state, including mid-wait on Mem_Ready, returns to START next edge. Mem_Req drops in that same cycle's output decode after the edge.

Decomposition:
- Package ctrl_pkg:
  - state enum (START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP).
  - opcode constants.
  - Imm_Ctrl encodings IMM_I..IMM_U.
  - Result_Src/ALU_Src encodings.
- No sub-module; single FSM file.

Test Plan:
- rst 3 cycles, RESET_PC_HOLD=1, Mem_Ready=1 → START 1 cycle with all outputs 0, then FETCH with Mem_Req=1, IR_Write=1.
- Opcode 0110011, Mem_Ready=1 → states FETCH, DECODE, EXEC_R, ALUWB; Reg_Write=1 only in cycle 4, ALU_Op=2 in cycle 3.
- Load 0000011, Mem_Ready low for 3 cycles in MEMRD → Mem_Req held 4 cycles with Adr_Src=1, then MEMWB Result_Src=1 Reg_Write=1; Imm_Ctrl=0 in MEMADR.
- Store 0100011 → Imm_Ctrl=1 in MEMADR, Mem_Write=1 in MEMWR, Reg_Write never asserted.
- Branch 1100011 with Branch_Taken=0 then 1 → DECODE Imm_Ctrl=2; BRANCH PC_Write=0 / 1 respectively.
- Opcode 1111111 → TRAP, Illegal=1 persists 10 cycles; rst mid-MEMWR wait → START next cycle, Mem_Req=0.
